// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - opcode constants and immediate-type codes for the immediate generator
package imm_gen_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

endpackage

// File: rtl/imm_decode_core.sv
// rtl/imm_decode_core.sv - combinational instruction-to-immediate decode
module imm_decode_core
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit CSR_EN = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        unused_funct3_lo;

    // only funct3[2] distinguishes CSR immediate forms; the rest is ignored
    assign unused_funct3_lo = ^instr[13:12];

    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR: begin
                imm32    = {{20{instr[31]}}, instr[31:20]};
                imm_type = IMM_I;
            end
            STORE: begin
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm_type = IMM_S;
            end
            BRANCH: begin
                imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                imm_type = IMM_B;
            end
            LUI, AUIPC: begin
                imm32    = {instr[31:12], 12'b0};
                imm_type = IMM_U;
            end
            JAL: begin
                imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                imm_type = IMM_J;
            end
            SYSTEM: begin
                if (CSR_EN && instr[14]) begin
                    imm32    = {27'b0, instr[19:15]};
                    imm_type = IMM_Z;
                end
            end
            OP, MISC_MEM: begin
                imm32 = '0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // zimm has bit 31 clear, so plain sign extension of imm32 is correct for every format
    generate
        if (XLEN > 32) begin : g_wide
            assign imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign imm = imm32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - one-cycle immediate generator with two-entry skid buffer
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit CSR_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       imm_type,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic            dec_illegal;

    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_type;
    logic            skid_illegal;

    logic            accept;
    logic            take;

    imm_decode_core #(
        .XLEN   (XLEN),
        .CSR_EN (CSR_EN)
    ) u_decode (
        .instr    (instr),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    // ready comes straight from a flop, so it never sees out_ready combinationally
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready && !flush;
    assign take     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            imm          <= '0;
            imm_type     <= IMM_NONE;
            illegal      <= 1'b0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_type    <= IMM_NONE;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || take) begin
            // skid_valid implies in_ready=0, so a skid refill and an accept never coincide
            if (skid_valid) begin
                out_valid  <= 1'b1;
                imm        <= skid_imm;
                imm_type   <= skid_type;
                illegal    <= skid_illegal;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                imm       <= dec_imm;
                imm_type  <= dec_type;
                illegal   <= dec_illegal;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_type    <= dec_type;
            skid_illegal <= dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] imm_a;
    logic [2:0]  type_a;
    logic [1:0]  cnt_a;

    logic        in_ready_b, out_valid_b, illegal_b;
    logic [63:0] imm_b;
    logic [2:0]  type_b;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CSR_EN(1'b1), .CNT_W(2)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready_a),
        .instr       (instr),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready),
        .imm         (imm_a),
        .imm_type    (type_a),
        .illegal     (illegal_a),
        .illegal_cnt (cnt_a)
    );

    imm_gen_pipe #(.XLEN(64), .CSR_EN(1'b0), .CNT_W(16)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready_b),
        .instr       (instr),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready),
        .imm         (imm_b),
        .imm_type    (type_b),
        .illegal     (illegal_b),
        .illegal_cnt (cnt_b)
    );

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_one(input logic [31:0] w);
        in_valid = 1'b1; instr = w; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid_a); end
        checks++; if (imm_a !== 32'h0) begin errors++; $display("FAIL reset imm got %h exp 0", imm_a); end
        checks++; if (type_a !== 3'd0) begin errors++; $display("FAIL reset imm_type got %0d exp 0", type_a); end
        checks++; if (illegal_a !== 1'b0) begin errors++; $display("FAIL reset illegal got %b exp 0", illegal_a); end
        checks++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL reset illegal_cnt got %0d exp 0", cnt_a); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready_a); end
        checks++; if (out_valid_b !== 1'b0 || imm_b !== 64'h0) begin errors++; $display("FAIL reset rv64 valid/imm got %b/%h exp 0/0", out_valid_b, imm_b); end
    endtask

    task automatic test_formats();
        logic [31:0] v   [14] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h123452B7,
                                  32'h800002B7, 32'h001000EF, 32'hFFDFF06F, 32'h00000463,
                                  32'h800080E7, 32'hFFFFF117, 32'h300FD073, 32'h00000073,
                                  32'h002081B3, 32'h0000007F};
        logic [31:0] e32 [14] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h12345000,
                                  32'h80000000, 32'h00000800, 32'hFFFFFFFC, 32'h00000008,
                                  32'hFFFFF800, 32'hFFFFF000, 32'h0000001F, 32'h00000000,
                                  32'h00000000, 32'h00000000};
        logic [63:0] e64 [14] = '{64'hFFFFFFFFFFFFFFFF, 64'h000000000000000C, 64'hFFFFFFFFFFFFFFFC,
                                  64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h0000000000000800,
                                  64'hFFFFFFFFFFFFFFFC, 64'h0000000000000008, 64'hFFFFFFFFFFFFF800,
                                  64'hFFFFFFFFFFFFF000, 64'h0000000000000000, 64'h0000000000000000,
                                  64'h0000000000000000, 64'h0000000000000000};
        logic [2:0]  t32 [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd3, 3'd1, 3'd4, 3'd6, 3'd0, 3'd0, 3'd0};
        logic [2:0]  t64 [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd3, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
        logic        ill [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 14; k++) begin
            drive_one(v[k]);
            checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL fmt[%0d] out_valid got %b exp 1", k, out_valid_a); end
            checks++; if (imm_a !== e32[k]) begin errors++; $display("FAIL fmt[%0d] imm32 got %h exp %h", k, imm_a, e32[k]); end
            checks++; if (type_a !== t32[k]) begin errors++; $display("FAIL fmt[%0d] type32 got %0d exp %0d", k, type_a, t32[k]); end
            checks++; if (illegal_a !== ill[k]) begin errors++; $display("FAIL fmt[%0d] illegal32 got %b exp %b", k, illegal_a, ill[k]); end
            checks++; if (imm_b !== e64[k]) begin errors++; $display("FAIL fmt[%0d] imm64 got %h exp %h", k, imm_b, e64[k]); end
            checks++; if (type_b !== t64[k]) begin errors++; $display("FAIL fmt[%0d] type64 got %0d exp %0d", k, type_b, t64[k]); end
            checks++; if (illegal_b !== ill[k]) begin errors++; $display("FAIL fmt[%0d] illegal64 got %b exp %b", k, illegal_b, ill[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [3] = '{32'hFFF00093, 32'h00112623, 32'h123452B7};
        logic [31:0] e [3] = '{32'hFFFFFFFF, 32'h0000000C, 32'h12345000};
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = v[0];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (k < 2) instr = v[k+1];
            else in_valid = 1'b0;
            @(negedge clk);
            checks++; if (out_valid_a !== 1'b1 || imm_a !== e[k]) begin errors++; $display("FAIL b2b[%0d] valid/imm got %b/%h exp 1/%h", k, out_valid_a, imm_a, e[k]); end
            checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL b2b[%0d] in_ready got %b exp 1", k, in_ready_a); end
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL b2b drain out_valid got %b exp 0", out_valid_a); end
    endtask

    task automatic test_backpressure();
        logic [31:0] v [4] = '{32'hFFF00093, 32'h00112623, 32'h123452B7, 32'h001000EF};
        logic [31:0] e [4] = '{32'hFFFFFFFF, 32'h0000000C, 32'h12345000, 32'h00000800};
        int idx;
        int rcv;
        logic acc, tk;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr = v[0];
        @(posedge clk); #1 instr = v[1];
        @(negedge clk);
        checks++; if (in_ready_a !== 1'b1 || imm_a !== e[0]) begin errors++; $display("FAIL bp c1 in_ready/imm got %b/%h exp 1/%h", in_ready_a, imm_a, e[0]); end
        @(posedge clk); #1 instr = v[2];
        @(negedge clk);
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL bp c2 in_ready got %b exp 0", in_ready_a); end
        checks++; if (out_valid_a !== 1'b1 || imm_a !== e[0]) begin errors++; $display("FAIL bp c2 hold got %b/%h exp 1/%h", out_valid_a, imm_a, e[0]); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready_a !== 1'b0 || imm_a !== e[0]) begin errors++; $display("FAIL bp c3 in_ready/imm got %b/%h exp 0/%h", in_ready_a, imm_a, e[0]); end
        out_ready = 1'b1;
        idx = 2;
        rcv = 0;
        for (int cyc = 0; cyc < 20 && rcv < 4; cyc++) begin
            acc = in_valid && in_ready_a;
            tk  = out_valid_a && out_ready;
            if (tk) begin
                checks++; if (imm_a !== e[rcv]) begin errors++; $display("FAIL bp out[%0d] imm got %h exp %h", rcv, imm_a, e[rcv]); end
                rcv++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) instr = v[idx];
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (rcv != 4) begin errors++; $display("FAIL bp count got %0d exp 4", rcv); end
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL bp duplicate out_valid got %b exp 0", out_valid_a); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0000007F;
        @(posedge clk); #1 instr = 32'hFFF00093;
        @(posedge clk); #1 instr = 32'h0000007F; flush = 1'b1;
        @(negedge clk);
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL flush pre in_ready got %b exp 0", in_ready_a); end
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL flush out_valid got %b exp 0", out_valid_a); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL flush in_ready got %b exp 1", in_ready_a); end
        checks++; if (cnt_a !== 2'd1) begin errors++; $display("FAIL flush illegal_cnt got %0d exp 1", cnt_a); end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL flush stale out_valid got %b exp 0", out_valid_a); end
        drive_one(32'h00112623);
        checks++; if (out_valid_a !== 1'b1 || imm_a !== 32'h0000000C) begin errors++; $display("FAIL flush resume got %b/%h exp 1/0000000c", out_valid_a, imm_a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0000007F;
        @(posedge clk); #1 instr = 32'hFFF00093;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (illegal_a !== 1'b1 || in_ready_a !== 1'b0) begin errors++; $display("FAIL rstmid pre illegal/in_ready got %b/%b exp 1/0", illegal_a, in_ready_a); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid_a !== 1'b0 || illegal_a !== 1'b0 || imm_a !== 32'h0 || type_a !== 3'd0) begin
            errors++; $display("FAIL rstmid outputs got v%b i%b imm%h t%0d exp 0", out_valid_a, illegal_a, imm_a, type_a); end
        checks++; if (cnt_a !== 2'd0 || cnt_b !== 16'd0) begin errors++; $display("FAIL rstmid illegal_cnt got %0d/%0d exp 0/0", cnt_a, cnt_b); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rstmid in_ready got %b exp 1", in_ready_a); end
    endtask

    task automatic test_illegal_cnt();
        logic [1:0]  ea [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_one(32'h0000007F);
            checks++; if (illegal_a !== 1'b1) begin errors++; $display("FAIL cnt[%0d] illegal got %b exp 1", k, illegal_a); end
            checks++; if (cnt_a !== ea[k]) begin errors++; $display("FAIL cnt[%0d] cnt2 got %0d exp %0d", k, cnt_a, ea[k]); end
            checks++; if (cnt_b !== 16'(k + 1)) begin errors++; $display("FAIL cnt[%0d] cnt16 got %0d exp %0d", k, cnt_b, k + 1); end
        end
        drive_one(32'hFFF00093);
        checks++; if (cnt_a !== 2'd3 || illegal_a !== 1'b0) begin errors++; $display("FAIL cnt legal got %0d/%b exp 3/0", cnt_a, illegal_a); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        test_reset();
        test_formats();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_illegal_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
